hack_data_memory: RTL

//  Hack data-memory stage directly downstream of the CPU: consumes addRAM/outRAM/enM, returns inRAM.

---
 rtl/hack_data_memory.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/hack_data_memory.sv
// Hack data-memory stage sitting directly behind the CPU.
// Decodes a = addRAM[14:0] into general RAM, the screen region (0x4000..0x5FFF),
// the keyboard register (0x6000) and unmapped space. Screen writes are streamed
// to a display driver through a small first-word-fall-through valid/ready FIFO.
// Key codes are latched from a keyboard driver through a ready/valid handshake.
//
// Optional feature macro: HACK_SCREEN_READBACK_EN
//   defined   - an 8K x N screen array shadows every screen write (dropped FIFO
//               pushes included), and screen reads return the stored word.
//   undefined - no screen array; screen reads return 0 (write-only stream).
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   addRAM     CPU data address (bit 15 ignored)
//   outRAM     CPU write data
//   enM        CPU write enable
//   inRAM      combinational read data for addRAM
//   kbd_valid  keyboard driver offers a key code
//   kbd_data   key code (0 is not a key)
//   kbd_ready  keyboard register empty
//   scr_valid  FIFO head valid
//   scr_ready  display driver accepts the head
//   scr_addr   head screen word offset (addr - 0x4000)
//   scr_data   head pixel word
//   scr_ovf    sticky flag: a screen write was dropped

module hack_data_memory #(
    parameter int unsigned N          = 16,
    parameter int unsigned RAM_WORDS  = 16384,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   addRAM,
    input  logic [N-1:0]  outRAM,
    input  logic          enM,
    output logic [N-1:0]  inRAM,
    input  logic          kbd_valid,
    input  logic [N-1:0]  kbd_data,
    output logic          kbd_ready,
    output logic          scr_valid,
    input  logic          scr_ready,
    output logic [12:0]   scr_addr,
    output logic [N-1:0]  scr_data,
    output logic          scr_ovf
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SCR_AW = 13;

    typedef struct packed {
        logic [SCR_AW-1:0] addr;
        logic [N-1:0]      data;
    } scr_entry_t;

    // Address decode
    logic [14:0] a;
    logic        sel_ram;
    logic        sel_scr;
    logic        sel_kbd;
    logic        unused_addr_msb;

    assign a               = addRAM[14:0];
    assign unused_addr_msb = addRAM[15];
    assign sel_ram         = (a < 15'(RAM_WORDS));
    assign sel_scr         = (a[14:13] == 2'b10);
    assign sel_kbd         = (a == 15'h6000);

    // General RAM: not reset, written on posedge
    logic [N-1:0] ram_mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (enM && sel_ram) begin
            ram_mem[a[RAM_AW-1:0]] <= outRAM;
        end
    end

`ifdef HACK_SCREEN_READBACK_EN
    // Screen shadow array, written even when the FIFO push is dropped
    logic [N-1:0] scr_mem [1 << SCR_AW];

    always_ff @(posedge clk) begin
        if (enM && sel_scr) begin
            scr_mem[a[SCR_AW-1:0]] <= outRAM;
        end
    end
`endif

    // Keyboard register
    logic [N-1:0] kreg_q;
    logic [N-1:0] kreg_d;

    assign kbd_ready = (kreg_q == '0);

    // CPU clear has priority over an incoming key
    always_comb begin
        kreg_d = kreg_q;
        if (enM && sel_kbd) begin
            kreg_d = '0;
        end else if (kbd_valid && kbd_ready && (kbd_data != '0)) begin
            kreg_d = kbd_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kreg_q <= '0;
        end else begin
            kreg_q <= kreg_d;
        end
    end

    // Screen-write FIFO
    scr_entry_t        fifo_mem [FIFO_DEPTH];
    scr_entry_t        head;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              full;
    logic              push_req;
    logic              push;
    logic              pop;

    assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign scr_valid = (cnt_q != '0);
    assign pop       = scr_valid && scr_ready;
    assign push_req  = enM && sel_scr;
    // A simultaneous pop frees the slot, so a full FIFO can still take the push
    assign push      = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{addr: a[SCR_AW-1:0], data: outRAM};
        end
    end

    // Head is gated so the stream outputs read 0 whenever the FIFO is empty
    assign head     = fifo_mem[rd_ptr_q];
    assign scr_addr = scr_valid ? head.addr : '0;
    assign scr_data = scr_valid ? head.data : '0;
    assign scr_ovf  = ovf_q;

    // Read mux; holes and unmapped space read 0
    always_comb begin
        inRAM = '0;
        if (sel_ram) begin
            inRAM = ram_mem[a[RAM_AW-1:0]];
        end else if (sel_kbd) begin
            inRAM = kreg_q;
        end
`ifdef HACK_SCREEN_READBACK_EN
        else if (sel_scr) begin
            inRAM = scr_mem[a[SCR_AW-1:0]];
        end
`endif
    end

endmodule
